// File: rtl/sub_bytes_engine.sv
// Forward AES SubBytes engine: 128-bit state, BYTES_PER_CYCLE S-box lanes, valid/ready handshakes.
// Optional SUB_BYTES_SELFCHECK_EN: each lane re-inverts its output and flags a sticky sbox_err on mismatch.

module sub_bytes_lane (
  input  logic [7:0] din,
`ifdef SUB_BYTES_SELFCHECK_EN
  output logic       err,
`endif
  output logic [7:0] dout
);
  // Row r holds S(r0)..S(rF), column 0 in the top byte.
  localparam logic [0:15][127:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // 15 - col == ~col for a 4-bit column index.
  assign dout = SBOX[din[7:4]][{~din[3:0], 3'b000} +: 8];

`ifdef SUB_BYTES_SELFCHECK_EN
  // Inverse S-box computed arithmetically so it cannot share a typo with the table.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r, s;
    r = 8'h01;
    s = x;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  logic [7:0] unaff;
  assign unaff = {dout[6:0], dout[7]} ^ {dout[4:0], dout[7:5]} ^ {dout[1:0], dout[7:2]} ^ 8'h05;
  assign err   = (gf_inv(unaff) != din);
`endif
endmodule

module sub_bytes_engine #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] input_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] subbed_block,
  output logic         sbox_err
);
  localparam int PASSES = 16 / BYTES_PER_CYCLE;
  localparam int CW     = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(PASSES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                           state, state_nxt;
  logic [CW-1:0]                    cnt;
  logic [15:0][7:0]                 work, work_nxt;
  logic [3:0]                       base;
  logic [BYTES_PER_CYCLE-1:0][7:0]  lane_out;

  assign base         = 4'(int'(cnt) * BYTES_PER_CYCLE);
  assign subbed_block = work;

`ifdef SUB_BYTES_SELFCHECK_EN
  logic [BYTES_PER_CYCLE-1:0] lane_err;
  logic                       err_q;
  assign sbox_err = err_q;
`else
  assign sbox_err = 1'b0;
`endif

  for (genvar l = 0; l < BYTES_PER_CYCLE; l++) begin : g_lane
    sub_bytes_lane u_lane (
      .din  (work[base + 4'(l)]),
`ifdef SUB_BYTES_SELFCHECK_EN
      .err  (lane_err[l]),
`endif
      .dout (lane_out[l])
    );
  end

  always_comb begin
    work_nxt = work;
    for (int l = 0; l < BYTES_PER_CYCLE; l++)
      work_nxt[base + 4'(l)] = lane_out[l];
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: if (cnt == LAST_CNT) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
      cnt   <= '0;
      work  <= '0;
`ifdef SUB_BYTES_SELFCHECK_EN
      err_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        work <= input_block;
        cnt  <= '0;
      end else if (state == BUSY) begin
        work <= work_nxt;
        // Counter parks on the last pass instead of wrapping.
        if (cnt != LAST_CNT) cnt <= cnt + 1'b1;
`ifdef SUB_BYTES_SELFCHECK_EN
        if (|lane_err) err_q <= 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_sub_bytes_engine.sv
// Bench for sub_bytes_engine: four instances (BPC 1,2,4,16) share stimulus and are checked
// against a GF(2^8) inverse + affine reference S-box.
module tb_sub_bytes_engine;
  logic               clk = 1'b0;
  logic               n_rst;
  logic               in_valid;
  logic               out_ready;
  logic [127:0]       input_block;
  logic [3:0]         ir, ov, err;
  logic [3:0][127:0]  sb;

  int n_chk = 0;
  int n_err = 0;
  int sbox_tab [256];

  always #5 clk = ~clk;

  function automatic int bpc_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sub_bytes_engine #(.BYTES_PER_CYCLE((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16)) u_dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .in_valid     (in_valid),
      .in_ready     (ir[g]),
      .input_block  (input_block),
      .out_valid    (ov[g]),
      .out_ready    (out_ready),
      .subbed_block (sb[g]),
      .sbox_err     (err[g])
    );
  end

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    int p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b & 1) p = p ^ a;
      a = a << 1;
      if (a & 'h100) a = a ^ 'h11b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic int sbox_calc(input int x);
    int inv = 0;
    int r;
    if (x != 0)
      for (int y = 1; y < 256; y++) if (gmul(x, y) == 1) inv = y;
    r = inv;
    for (int k = 1; k <= 4; k++) r = r ^ (((inv << k) | (inv >> (8 - k))) & 'hff);
    return r ^ 'h63;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] b);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'(sbox_tab[b[8*i +: 8]]);
    return r;
  endfunction

  // Push one block through all instances with out_ready high; checks latency, data, pulse width.
  task automatic send(input logic [127:0] blk, input string tag, output logic [127:0] main_out);
    int lat [4];
    int hi [4];
    logic [127:0] got [4];
    for (int g = 0; g < 4; g++) begin lat[g] = 0; hi[g] = 0; got[g] = '0; end
    @(negedge clk);
    input_block = blk;
    in_valid    = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      @(posedge clk);
      @(negedge clk);
      in_valid    = 1'b0;
      input_block = {$urandom, $urandom, $urandom, $urandom};
      for (int g = 0; g < 4; g++)
        if (ov[g]) begin
          if (lat[g] == 0) begin lat[g] = e; got[g] = sb[g]; end
          hi[g]++;
        end
    end
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("%s_lat_bpc%0d", tag, bpc_of(g)), 128'(lat[g]), 128'(16 / bpc_of(g) + 1));
      chk($sformatf("%s_data_bpc%0d", tag, bpc_of(g)), got[g], model(blk));
      chk($sformatf("%s_pulse_bpc%0d", tag, bpc_of(g)), 128'(hi[g]), 128'd1);
      chk($sformatf("%s_err_bpc%0d", tag, bpc_of(g)), 128'(err[g]), 128'd0);
    end
    main_out = got[2];
  endtask

  initial begin
    logic [127:0] res, blk_a;
    int seen;
    n_rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; input_block = '0;
    for (int x = 0; x < 256; x++) sbox_tab[x] = sbox_calc(x);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(ir), 128'hf);
    chk("rst_out_valid", 128'(ov), 128'h0);
    chk("rst_err", 128'(err), 128'h0);
    for (int g = 0; g < 4; g++) chk($sformatf("rst_data_bpc%0d", bpc_of(g)), sb[g], '0);
    n_rst = 1'b1;

    // Known-answer vectors
    send(128'h0, "zero", res);
    chk("zero_const", res, {16{8'h63}});
    send(128'h00112233445566778899aabbccddeeff, "kat", res);
    chk("kat_const", res, 128'h638293c31bfc33f5c4eeacea4bc12816);

    // Random blocks
    for (int i = 0; i < 12; i++) send({$urandom, $urandom, $urandom, $urandom}, "rand", res);

    // Backpressure: hold result, ignore a second block while DONE
    blk_a = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b0;
    @(negedge clk);
    input_block = blk_a; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 40 && !(&ov); i++) @(negedge clk);
    chk("bp_wait_done", 128'(&ov), 128'd1);
    for (int c = 0; c < 10; c++) begin
      input_block = {$urandom, $urandom, $urandom, $urandom};
      in_valid    = 1'b1;
      @(negedge clk);
      chk("bp_out_valid", 128'(ov), 128'hf);
      chk("bp_in_ready", 128'(ir), 128'h0);
      for (int g = 0; g < 4; g++) chk($sformatf("bp_hold_bpc%0d", bpc_of(g)), sb[g], model(blk_a));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ov", 128'(ov), 128'h0);
    chk("bp_release_ir", 128'(ir), 128'hf);
    send({$urandom, $urandom, $urandom, $urandom}, "after_bp", res);

    // Reset while BUSY (BPC=4 instance at cnt==2)
    @(negedge clk);
    input_block = {$urandom, $urandom, $urandom, $urandom}; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0; n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    chk("midrst_ov", 128'(ov), 128'h0);
    chk("midrst_ir", 128'(ir), 128'hf);
    chk("midrst_data", sb[2], '0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (|ov) seen++;
    end
    chk("midrst_no_output", 128'(seen), 128'd0);
    send({128{1'b1}}, "ones", res);
    chk("ones_const", res, {16{8'h16}});

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
